// File: rtl/instr_memory.sv
// Word-addressed instruction/data memory model serving single and burst
// reads to the fetch stage and burst writes from the loader. Read beats
// appear one per cycle with valid_out; busy_out covers the whole burst.
module instr_memory #(
  parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic [31:0] addr_in,
  input  logic        rw_in,
  input  logic [1:0]  access_size_in,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        busy_out,
  output logic        error_out
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned LW = 5;
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } state_e;

  state_e        state_q;
  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          busy_q;
  logic          error_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] last_q;
  logic [AW-1:0] base_q;

  logic [DW-1:0] mem_q [DEPTH_WORDS];

  logic [LW-1:0] req_len;
  logic [31:0]   word_off;
  logic [AW-1:0] req_idx;
  logic          req_bad;
  logic          accept;
  logic [AW-1:0] beat_idx;
  logic [AW-1:0] next_idx;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  // Burst length in words from the size code
  always_comb begin
    req_len = LW'(1);
    unique case (access_size_in)
      2'b00:   req_len = LW'(1);
      2'b01:   req_len = LW'(4);
      2'b10:   req_len = LW'(8);
      default: req_len = LW'(16);
    endcase
  end

  // Request decode: word index and rejection (misaligned, below base, or
  // burst running past the last word; no wrap-around)
  always_comb begin
    word_off = (addr_in - BASE_ADDR) >> 2;
    req_idx  = word_off[AW-1:0];
    req_bad  = (addr_in[1:0] != 2'b00) ||
               (addr_in < BASE_ADDR) ||
               ((word_off + 32'(req_len)) > 32'(DEPTH_WORDS));
    accept   = enable_in && !busy_q;
    beat_idx = base_q + AW'(cnt_q);
    next_idx = base_q + AW'(cnt_q + CW'(1));
  end

  // Write port select; a reset edge blocks any write so aborted beats are lost
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = req_idx;
    if (!rst_in) begin
      if (state_q == IDLE && accept && rw_in && !req_bad) begin
        wr_en   = 1'b1;
        wr_addr = req_idx;
      end else if (state_q == WR_BURST) begin
        wr_en   = 1'b1;
        wr_addr = beat_idx;
      end
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem_q[wr_addr] <= data_in;
    end
  end

  // Burst sequencer with registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
      cnt_q   <= '0;
      last_q  <= '0;
      base_q  <= '0;
    end else begin
      error_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (req_bad) begin
              error_q <= 1'b1;
            end else begin
              base_q <= req_idx;
              last_q <= CW'(req_len - LW'(1));
              if (!rw_in) begin
                state_q <= RD_BURST;
                data_q  <= mem_q[req_idx];
                valid_q <= 1'b1;
                busy_q  <= 1'b1;
                cnt_q   <= '0;
              end else if (req_len != LW'(1)) begin
                // beat 0 is written on the accept edge; continue from beat 1
                state_q <= WR_BURST;
                busy_q  <= 1'b1;
                cnt_q   <= CW'(1);
              end
            end
          end
        end
        RD_BURST: begin
          if (cnt_q == last_q) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q  <= cnt_q + CW'(1);
            data_q <= mem_q[next_idx];
          end
        end
        WR_BURST: begin
          if (cnt_q == last_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign busy_out  = busy_q;
  assign error_out = error_q;

endmodule
